// File: rtl/pipe_mux_stage_pkg.sv
// Shared helpers for the N-way registered selector stage.
// Select-range check and the data substituted for a bad select.
package pipe_mux_stage_pkg;

    localparam bit SEL_ERR_DATA = 1'b0;

    function automatic logic sel_valid(input int unsigned sel, input int unsigned num_in);
        return sel < num_in;
    endfunction

endpackage

// File: rtl/pipe_mux_stage_if.sv
// Handshake bundle between upstream sources, the mux stage and downstream.
// master drives beats in and consumes results; slave is the stage.
interface pipe_mux_stage_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
);
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic                    flush;
    logic [WIDTH-1:0]        out_data;
    logic                    out_sel_err;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_data, sel, in_valid, flush, out_ready,
        input  in_ready, out_data, out_sel_err, out_valid
    );

    modport slave (
        input  in_data, sel, in_valid, flush, out_ready,
        output in_ready, out_data, out_sel_err, out_valid
    );
endinterface

// File: rtl/pipe_mux_stage_skid.sv
// Two-entry pipeline register: main output entry plus one skid entry.
// in_ready comes straight from the skid flag, never from out_ready.
module skid_reg #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);
    logic [W-1:0] skid_data;
    logic         skid_valid;
    logic         accept;
    logic         load_main;

    assign in_ready  = ~skid_valid;
    assign accept    = in_valid & in_ready;
    assign load_main = ~out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (load_main) begin
            // A full skid blocks accept, so it always drains first
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end
endmodule

// File: rtl/pipe_mux_stage.sv
// N-way WIDTH-bit selector feeding a stallable, flushable register stage.
// Out-of-range selects pass zero data with an error flag.
module pipe_mux_stage
    import pipe_mux_stage_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input logic               clk,
    input logic               reset,
    pipe_mux_stage_if.slave   bus
);
    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    logic [WIDTH:0]   out_word;

    always_comb begin
        sel_data = {WIDTH{SEL_ERR_DATA}};
        sel_err  = ~sel_valid(32'(bus.sel), NUM_IN);
        for (int i = 0; i < NUM_IN; i++) begin
            if (32'(bus.sel) == i) sel_data = bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    skid_reg #(.W(WIDTH + 1)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.flush),
        .in_data   ({sel_err, sel_data}),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .out_data  (out_word),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready)
    );

    assign bus.out_data    = out_word[WIDTH-1:0];
    assign bus.out_sel_err = out_word[WIDTH];
endmodule

// File: tb/tb_pipe_mux_stage.sv
// Scoreboard bench: NUM_IN=4 and NUM_IN=3 stages share one stimulus stream.
// A queue model of held beats predicts valid/ready/data for both.
module tb_pipe_mux_stage;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic         in_valid, out_ready, flush;
    logic [1:0]   sel;
    logic [W-1:0] src [4];

    pipe_mux_stage_if #(.WIDTH(W), .NUM_IN(4)) b4 ();
    pipe_mux_stage_if #(.WIDTH(W), .NUM_IN(3)) b3 ();

    assign b4.in_data   = {src[3], src[2], src[1], src[0]};
    assign b4.sel       = sel;
    assign b4.in_valid  = in_valid;
    assign b4.flush     = flush;
    assign b4.out_ready = out_ready;
    assign b3.in_data   = {src[2], src[1], src[0]};
    assign b3.sel       = sel;
    assign b3.in_valid  = in_valid;
    assign b3.flush     = flush;
    assign b3.out_ready = out_ready;

    pipe_mux_stage #(.WIDTH(W), .NUM_IN(4)) d4 (.clk(clk), .reset(reset), .bus(b4.slave));
    pipe_mux_stage #(.WIDTH(W), .NUM_IN(3)) d3 (.clk(clk), .reset(reset), .bus(b3.slave));

    typedef struct {
        logic [W-1:0] d4;
        logic [W-1:0] d3;
        bit           e3;
    } beat_t;

    beat_t q[$];
    int checks = 0;
    int failures = 0;
    bit armed = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare current outputs, then advance the model across the next edge
    always @(negedge clk) begin
        if (armed) begin
            chk("valid4", 32'(b4.out_valid), 32'(q.size() > 0));
            chk("valid3", 32'(b3.out_valid), 32'(q.size() > 0));
            chk("ready4", 32'(b4.in_ready), 32'(q.size() < 2));
            chk("ready3", 32'(b3.in_ready), 32'(q.size() < 2));
            if (q.size() > 0 && b4.out_valid && b3.out_valid) begin
                chk("data4", 32'(b4.out_data), 32'(q[0].d4));
                chk("err4", 32'(b4.out_sel_err), 32'd0);
                chk("data3", 32'(b3.out_data), 32'(q[0].d3));
                chk("err3", 32'(b3.out_sel_err), 32'(q[0].e3));
            end
        end
        if (reset) begin
            q.delete();
            armed = 1;
        end else if (armed) begin
            int n;
            beat_t b;
            n = q.size();
            if (flush) begin
                q.delete();
            end else begin
                if (n > 0 && out_ready) void'(q.pop_front());
                if (in_valid && n < 2) begin
                    b.d4 = src[sel];
                    b.e3 = (sel >= 2'd3);
                    b.d3 = b.e3 ? '0 : src[sel];
                    q.push_back(b);
                end
            end
        end
    end

    task automatic step(bit v, logic [1:0] s, bit ordy, bit fl);
        in_valid  = v;
        sel       = s;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1;
        in_valid = 0; sel = 0; out_ready = 0; flush = 0;
        src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33; src[3] = 8'h44;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        reset = 0;
        #1;
        chk("rst_data4", 32'(b4.out_data), 32'd0);
        chk("rst_err4", 32'(b4.out_sel_err), 32'd0);
        chk("rst_data3", 32'(b3.out_data), 32'd0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        // streaming at full rate
        for (int i = 0; i < 4; i++) step(1, 2'(i), 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        // backpressure: two beats held, then drained
        step(1, 1, 0, 0);
        step(1, 2, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);

        // out-of-range on the 3-way stage, then in-range
        step(1, 3, 1, 0);
        step(1, 0, 1, 0);
        step(0, 0, 1, 0);

        // flush with two held beats plus one presented in the flush cycle
        step(1, 1, 0, 0);
        step(1, 2, 0, 0);
        step(1, 3, 0, 1);
        step(0, 0, 0, 0);
        step(1, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        // reset mid-stall
        step(1, 1, 0, 0);
        step(1, 2, 0, 0);
        reset = 1;
        step(0, 0, 0, 0);
        reset = 0;
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < 4; k++) src[k] = W'($urandom);
            step(bit'($urandom_range(0, 3) != 0), 2'($urandom),
                 bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 24) == 0));
        end
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_mux_stage.md
Name: pipe_mux_stage

Overview:
- Parametrised N-way, WIDTH-bit selector with a registered output stage and a valid/ready handshake.
- Successor to the plain 2:1 combinational selectors. Used where the datapath needs a selectable source plus a stallable, flushable pipeline boundary, e.g. forwarding-source choice ahead of a stage register.
- A 1-entry skid buffer lets in_ready be driven from a register rather than from out_ready, so the handshake can cross stages without a combinational ready path.

Parameters:
- WIDTH, 32, data width in bits.
- NUM_IN, 4, number of selectable inputs (>=2).
- SEL_W, $clog2(NUM_IN), width of sel (derived; do not override).

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  NUM_IN*WIDTH  packed sources; source i occupies bits [i*WIDTH +: WIDTH].
- sel  input  SEL_W  binary source index, sampled with in_valid.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  stage can accept a beat.
- flush  input  1  discard all held and incoming beats.
- out_data  output  WIDTH  registered selected data.
- out_sel_err  output  1  registered alongside out_data; 1 if that beat's sel was >= NUM_IN.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts.

Behaviour:
- Reset and clock: one clock; reset is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_sel_err=0. Skid entry is empty, so in_ready=1 in the cycle after reset. While reset is high, in_valid is ignored.
- Selection (combinational, before the register):
  - sel<NUM_IN: picks source sel.
  - sel>=NUM_IN (only possible when NUM_IN is not a power of two): picks all-zero data and sets err=1 for that beat.
- Accept rule: a beat is accepted when in_valid & in_ready at a rising edge. Accepted data+err appear on out_data/out_sel_err with out_valid=1 one cycle later (latency 1).
- in_ready = ~skid_valid, taken directly from the register with no combinational path from out_ready.
- Main register (out_*) update, on each edge:
  - Loads when out register empty, or out_valid & out_ready.
  - Load source is the skid entry if it is full, otherwise the incoming beat.
  - out_valid goes to 0 if nothing is available to load and the current beat was consumed.
- Skid entry:
  - Captures the incoming beat when it is accepted while out_valid=1 & out_ready=0.
  - Empties when its content moves into the main register.
- Ordering: beats leave in acceptance order; none is dropped or duplicated.
- Stalls: out_data/out_sel_err stay stable while out_valid=1 & out_ready=0.
- Max occupancy is 2 (main + skid). Full throughput is one beat per cycle when out_ready is held at 1.
- Flush (synchronous):
  - Next edge: out_valid=0, skid empty, in_ready=1.
  - Any beat presented in the flush cycle is discarded, even if in_valid&in_ready.
  - out_data keeps its last value (don't-care while invalid).
- Priority: reset > flush > normal operation.
- Simultaneous out consume + in accept with skid empty: the main register takes the new beat, the skid stays empty.
- Reset during a stall: both entries are dropped; no beat is emitted afterwards.

Decomposition:
- Shared package:
  - Function sel_valid(sel, NUM_IN).
  - Constant SEL_ERR_DATA = '0.
  - Typedef-free; widths stay as parameters.
- One natural sub-module: skid_reg (WIDTH+1 bits payload), holding main + skid entries and the valid/ready logic.
- Selector stays inline in pipe_mux_stage.

Test Plan:
- Reset then idle, NUM_IN=4: reset high 2 cycles -> out_valid=0, out_data=0, out_sel_err=0, in_ready=1 on the first cycle after release.
- Streaming, out_ready=1: sources {0x11,0x22,0x33,0x44}, sel=0,1,2,3 on consecutive cycles -> out_data 0x11,0x22,0x33,0x44 each one cycle later, out_valid continuously 1, in_ready continuously 1.
- Backpressure: send sel=1 then sel=2 with out_ready=0 -> out_data=0x22 held, in_ready falls to 0 after the 2nd beat. Raise out_ready -> 0x22 then 0x33 emitted, in_ready returns to 1.
- Out-of-range select, NUM_IN=3, SEL_W=2: sel=3 -> out_data=0, out_sel_err=1. Next beat sel=0 -> out_sel_err=0.
- Flush with two beats held (out_ready=0), plus a new beat presented in the flush cycle -> next cycle out_valid=0, in_ready=1. Later beats are emitted normally; the flushed/dropped beats never appear.
- Reset mid-stall: two beats held, reset pulse -> out_valid=0, in_ready=1; no held beat appears after release.
